// File: rtl/dmux_nway_pkg.sv
// dmux_nway_pkg -- shared definitions for the registered N-way demultiplexer.
//   slot_state_e : per-channel slot occupancy (EMPTY=0, FULL=1)
//   STAT_W       : width of the optional statistics counters
//   sat_inc      : saturating increment used by the statistics counters
package dmux_nway_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dmux_nway_slot.sv
// dmux_nway_slot -- one-entry output slot for a single demux channel.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : write data_i into the slot this cycle (slot becomes FULL)
//   data_i     : payload to load
//   drain_i    : consumer ready; drains the slot when it is FULL
//   valid_o    : slot is FULL (the slot state itself, registered)
//   data_o     : slot payload; keeps the last value after it is drained
// Handshake: a beat leaves when valid_o && drain_i at a rising edge. A load in
// the same cycle wins, so the slot stays FULL with the new data.
module dmux_nway_slot
  import dmux_nway_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             drain_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = SLOT_FULL;
      data_d  = data_i;
    end else if (drain_i && (state_q == SLOT_FULL)) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/dmux_nway_reg.sv
// dmux_nway_reg -- registered 1-to-WAYS demultiplexer with one slot per channel.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_data/in_sel        : upstream payload and destination channel
//   in_valid/in_ready     : upstream handshake
//   out_data              : channel k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready   : per-channel downstream handshake
//   drop_pulse            : one-cycle pulse after an out-of-range beat is discarded
//   stat_accepted/dropped : saturating counters, present only with DMUX_NWAY_STATS_EN
// Handshake: a beat transfers on any rising edge where valid && ready are both
// high; ready never depends on valid, and valid is not withdrawn by the producer
// while waiting.
// Build option: define DMUX_NWAY_STATS_EN to add the statistics counters.
module dmux_nway_reg
  import dmux_nway_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WAYS*WIDTH-1:0] out_data,
  output logic [WAYS-1:0]       out_valid,
  input  logic [WAYS-1:0]       out_ready,
  output logic                  drop_pulse
`ifdef DMUX_NWAY_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_accepted,
  output logic [STAT_W-1:0]     stat_dropped
`endif
);

  // One extra bit so WAYS itself is representable when it is a power of two.
  localparam logic [SEL_W:0] WAYS_L = (SEL_W + 1)'(WAYS);

  logic            in_range;
  logic            accept;
  logic [WAYS-1:0] hit;
  logic [WAYS-1:0] load;

  assign in_range = ({1'b0, in_sel} < WAYS_L);

  // One-hot decode; out-of-range selects hit nothing.
  always_comb begin
    hit = '0;
    for (int k = 0; k < WAYS; k++) begin
      hit[k] = (in_sel == SEL_W'(k));
    end
  end

  // Out-of-range beats are always taken (and discarded); in-range beats need
  // the target slot empty or draining this cycle.
  assign in_ready = !in_range || (|(hit & (~out_valid | out_ready)));
  assign accept   = in_valid && in_ready;
  assign load     = hit & {WAYS{accept}};

  for (genvar k = 0; k < WAYS; k++) begin : g_slot
    dmux_nway_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load[k]),
      .data_i (in_data),
      .drain_i(out_ready[k]),
      .valid_o(out_valid[k]),
      .data_o (out_data[k*WIDTH +: WIDTH])
    );
  end

  logic drop_q, drop_d;
  assign drop_d = accept && !in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_pulse = drop_q;

`ifdef DMUX_NWAY_STATS_EN
  logic [STAT_W-1:0] acc_q, acc_d;
  logic [STAT_W-1:0] drp_q, drp_d;

  assign acc_d = (accept && in_range) ? sat_inc(acc_q) : acc_q;
  assign drp_d = drop_d ? sat_inc(drp_q) : drp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      drp_q <= '0;
    end else begin
      acc_q <= acc_d;
      drp_q <= drp_d;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_dropped  = drp_q;
`endif

endmodule

// File: tb/tb_dmux_nway_reg.sv
// tb_dmux_nway_reg -- bench for dmux_nway_reg. Two instances: an 8-way one
// for routing/streaming/backpressure/random traffic, and a 6-way one so that
// out-of-range selects (6, 7) are reachable. Define DMUX_NWAY_STATS_EN to also
// exercise the statistics counters.
module tb_dmux_nway_reg;

  logic clk;
  logic rst_n;

  // 8-way instance
  logic [15:0]  in_data8;
  logic [2:0]   in_sel8;
  logic         in_valid8;
  logic         in_ready8;
  logic [127:0] out_data8;
  logic [7:0]   out_valid8;
  logic [7:0]   out_ready8;
  logic         drop8;

  // 6-way instance
  logic [15:0]  in_data6;
  logic [2:0]   in_sel6;
  logic         in_valid6;
  logic         in_ready6;
  logic [95:0]  out_data6;
  logic [5:0]   out_valid6;
  logic [5:0]   out_ready6;
  logic         drop6;

`ifdef DMUX_NWAY_STATS_EN
  logic [15:0] stat_acc8, stat_drop8, stat_acc6, stat_drop6;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];

  dmux_nway_reg #(.WIDTH(16), .WAYS(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data8),
    .in_sel    (in_sel8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .out_data  (out_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .drop_pulse(drop8)
`ifdef DMUX_NWAY_STATS_EN
    ,
    .stat_accepted(stat_acc8),
    .stat_dropped (stat_drop8)
`endif
  );

  dmux_nway_reg #(.WIDTH(16), .WAYS(6)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data6),
    .in_sel    (in_sel6),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
    .out_data  (out_data6),
    .out_valid (out_valid6),
    .out_ready (out_ready6),
    .drop_pulse(drop6)
`ifdef DMUX_NWAY_STATS_EN
    ,
    .stat_accepted(stat_acc6),
    .stat_dropped (stat_drop6)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_data8 = '0; in_sel8 = '0; in_valid8 = 1'b0; out_ready8 = '0;
    in_data6 = '0; in_sel6 = '0; in_valid6 = 1'b0; out_ready6 = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reset values, then a mid-operation reset with every slot FULL.
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (out_valid8 !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h expected 00", out_valid8); end
    checks++;
    if (out_data8 !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data8); end
    checks++;
    if (drop8 !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop8); end
    checks++;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready8); end
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      in_valid8 = 1'b1;
      in_sel8   = 3'(k);
      in_data8  = 16'($urandom_range(1, 16'hFFFF));
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid8 !== 8'hFF) begin errors++; $display("FAIL fill_valid: got %h expected ff", out_valid8); end
`ifdef DMUX_NWAY_STATS_EN
    checks++;
    if (stat_acc8 !== 16'd8) begin errors++; $display("FAIL fill_stat_acc: got %0d expected 8", stat_acc8); end
`endif
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid8 !== 8'h00) begin errors++; $display("FAIL midreset_valid: got %h expected 00", out_valid8); end
    checks++;
    if (out_data8 !== 128'h0) begin errors++; $display("FAIL midreset_data: got %h expected 0", out_data8); end
`ifdef DMUX_NWAY_STATS_EN
    checks++;
    if (stat_acc8 !== 16'd0) begin errors++; $display("FAIL midreset_stat_acc: got %0d expected 0", stat_acc8); end
`endif
    rst_n = 1'b1;
    in_sel8 = 3'd4;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", in_ready8); end
  endtask

  // Single beat to channel 5 with all consumers stalled.
  task automatic test_routing();
    logic [127:0] exp_data;
    apply_reset();
    exp_data = '0;
    exp_data[5*16 +: 16] = 16'hA5A5;
    in_data8 = 16'hA5A5; in_sel8 = 3'd5; in_valid8 = 1'b1; out_ready8 = 8'h00;
    @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL route_ready_empty: got %b expected 1", in_ready8); end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid8 !== 8'b0010_0000) begin errors++; $display("FAIL route_valid: got %b expected 00100000", out_valid8); end
    checks++;
    if (out_data8 !== exp_data) begin errors++; $display("FAIL route_data: got %h expected %h", out_data8, exp_data); end
    checks++;
    if (in_ready8 !== 1'b0) begin errors++; $display("FAIL route_ready_sel5: got %b expected 0", in_ready8); end
    #1;
    in_sel8 = 3'd2;
    #1;
    checks++;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL route_ready_sel2: got %b expected 1", in_ready8); end
  endtask

  // 100 back-to-back beats to channel 3 with the consumer always ready.
  task automatic test_streaming();
    int recv;
    logic [15:0] e;
    apply_reset();
    exp_q.delete();
    recv = 0;
    out_ready8 = 8'b0000_1000;
    for (int i = 0; i < 102; i++) begin
      in_valid8 = (i < 100);
      in_sel8   = 3'd3;
      in_data8  = 16'($urandom);
      @(negedge clk);
      if (i < 100) begin
        checks++;
        if (in_ready8 !== 1'b1) begin errors++; $display("FAIL stream_ready: cycle %0d got %b expected 1", i, in_ready8); end
      end
      if (i >= 1 && i <= 100) begin
        checks++;
        if (out_valid8[3] !== 1'b1) begin errors++; $display("FAIL stream_bubble: cycle %0d got %b expected 1", i, out_valid8[3]); end
      end
      if (out_valid8[3] === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        recv++;
        checks++;
        if (out_data8[3*16 +: 16] !== e) begin errors++; $display("FAIL stream_data: beat %0d got %h expected %h", recv, out_data8[3*16 +: 16], e); end
      end
      if (in_valid8) exp_q.push_back(in_data8);
      @(posedge clk); #1;
    end
    checks++;
    if (recv != 100) begin errors++; $display("FAIL stream_count: got %0d expected 100", recv); end
  endtask

  // Channel 1 with the consumer toggling ready every cycle.
  task automatic test_backpressure();
    int sent, recv;
    logic exp_rdy;
    logic [15:0] e;
    apply_reset();
    exp_q.delete();
    sent = 0; recv = 0;
    for (int i = 0; i < 64; i++) begin
      in_valid8     = (i < 56) ? ((i < 4) || ($urandom_range(0, 3) != 0)) : 1'b0;
      in_sel8       = 3'd1;
      in_data8      = 16'($urandom);
      out_ready8    = '0;
      out_ready8[1] = i[0];
      @(negedge clk);
      exp_rdy = (exp_q.size() == 0) || out_ready8[1];
      checks++;
      if (in_ready8 !== exp_rdy) begin errors++; $display("FAIL bp_ready: cycle %0d got %b expected %b", i, in_ready8, exp_rdy); end
      checks++;
      if (out_valid8[1] !== (exp_q.size() != 0)) begin errors++; $display("FAIL bp_valid: cycle %0d got %b expected %b", i, out_valid8[1], exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++;
        if (out_data8[1*16 +: 16] !== exp_q[0]) begin errors++; $display("FAIL bp_data: cycle %0d got %h expected %h", i, out_data8[1*16 +: 16], exp_q[0]); end
        if (out_ready8[1]) begin
          e = exp_q.pop_front();
          recv++;
        end
      end
      if (in_valid8 && exp_rdy) begin
        exp_q.push_back(in_data8);
        sent++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0 || sent != recv) begin errors++; $display("FAIL bp_count: got %0d recv expected %0d", recv, sent); end
  endtask

  // Random traffic on all 8 channels against a per-channel occupancy model.
  task automatic test_random();
    logic        mf[8];
    logic [15:0] mv[8];
    logic [7:0]   ev;
    logic [127:0] ed;
    logic         er;
    int           s;
    apply_reset();
    for (int k = 0; k < 8; k++) begin mf[k] = 1'b0; mv[k] = '0; end
    for (int i = 0; i < 300; i++) begin
      in_valid8  = ($urandom_range(0, 2) != 0);
      in_sel8    = 3'($urandom_range(0, 7));
      in_data8   = 16'($urandom);
      out_ready8 = 8'($urandom);
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        ev[k] = mf[k];
        ed[k*16 +: 16] = mv[k];
      end
      s  = int'(in_sel8);
      er = !mf[s] || out_ready8[s];
      checks++;
      if (out_valid8 !== ev) begin errors++; $display("FAIL rnd_valid: cycle %0d got %h expected %h", i, out_valid8, ev); end
      checks++;
      if (out_data8 !== ed) begin errors++; $display("FAIL rnd_data: cycle %0d got %h expected %h", i, out_data8, ed); end
      checks++;
      if (in_ready8 !== er) begin errors++; $display("FAIL rnd_ready: cycle %0d got %b expected %b", i, in_ready8, er); end
      checks++;
      if (drop8 !== 1'b0) begin errors++; $display("FAIL rnd_drop: cycle %0d got %b expected 0", i, drop8); end
      for (int k = 0; k < 8; k++) if (mf[k] && out_ready8[k]) mf[k] = 1'b0;
      if (in_valid8 && er) begin mf[s] = 1'b1; mv[s] = in_data8; end
      @(posedge clk); #1;
    end
  endtask

  // 6-way instance: selects 6 and 7 are discarded.
  task automatic test_out_of_range();
    logic [15:0] d;
    logic [95:0] ed;
    int exp_drop;
    apply_reset();
    exp_drop = 0;
    d = 16'($urandom_range(1, 16'hFFFF));
    ed = '0;
    ed[2*16 +: 16] = d;
    in_valid6 = 1'b1; in_sel6 = 3'd2; in_data6 = d;
    @(posedge clk); #1;
    for (int j = 0; j < 2; j++) begin
      in_valid6 = 1'b1;
      in_sel6   = (j == 0) ? 3'd7 : 3'd6;
      in_data6  = 16'($urandom);
      @(negedge clk);
      checks++;
      if (in_ready6 !== 1'b1) begin errors++; $display("FAIL oor_ready: sel %0d got %b expected 1", in_sel6, in_ready6); end
      exp_drop++;
      @(posedge clk); #1;
      in_valid6 = 1'b0;
      @(negedge clk);
      checks++;
      if (drop6 !== 1'b1) begin errors++; $display("FAIL oor_pulse: sel %0d got %b expected 1", in_sel6, drop6); end
      checks++;
      if (out_valid6 !== 6'b000100) begin errors++; $display("FAIL oor_valid: got %b expected 000100", out_valid6); end
      checks++;
      if (out_data6 !== ed) begin errors++; $display("FAIL oor_data: got %h expected %h", out_data6, ed); end
`ifdef DMUX_NWAY_STATS_EN
      checks++;
      if (stat_drop6 !== 16'(exp_drop)) begin errors++; $display("FAIL oor_stat_drop: got %0d expected %0d", stat_drop6, exp_drop); end
      checks++;
      if (stat_acc6 !== 16'd1) begin errors++; $display("FAIL oor_stat_acc: got %0d expected 1", stat_acc6); end
`endif
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (drop6 !== 1'b0) begin errors++; $display("FAIL oor_pulse_len: got %b expected 0", drop6); end
      @(posedge clk); #1;
    end
  endtask

`ifdef DMUX_NWAY_STATS_EN
  // 65540 accepted beats: the accept counter must stick at its maximum.
  task automatic test_saturation();
    apply_reset();
    out_ready8 = 8'b0000_1000;
    in_sel8    = 3'd3;
    in_valid8  = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      in_data8 = 16'(i);
      @(posedge clk);
    end
    #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if (stat_acc8 !== 16'hFFFF) begin errors++; $display("FAIL sat_acc: got %h expected ffff", stat_acc8); end
    checks++;
    if (stat_drop8 !== 16'h0000) begin errors++; $display("FAIL sat_drop: got %h expected 0000", stat_drop8); end
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_streaming();
    test_backpressure();
    test_random();
    test_out_of_range();
`ifdef DMUX_NWAY_STATS_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
